exp_sched_rr: RTL
=================

# exp_sched_rr

Round-robin scheduler that shares one pipelined exponential unit (`exp_taylor_pp`, fixed latency, no valid output) among several requesters. It grants one request per cycle and registers the selected operand into the unit. A tag shift register matched to the unit latency tracks each operand, so every result returns with a valid strobe and its requester ID. It sits between the requester-side datapaths and the single shared exp instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `LATENCY`, 6, cycles from operand registered at unit input to result stable at `iExpResult`
- `DATA_W`, 12, operand width, {4-bit signed int, 8-bit frac}
- `RES_W`, 20, result width, {12 int, 4 frac} zero-extended
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous reset, active low
- `iEn`  in  1  scheduler enable; low requests a drain-and-stop
- `iReq`  in  N_REQ  per-requester request, level
- `iData`  in  N_REQ*DATA_W  per-requester operand, slice i belongs to requester i
- `oGnt`  out  N_REQ  one-hot grant, combinational
- `oExpData`  out  DATA_W  registered operand to exp unit `iData`
- `oExpValid`  out  1  registered; `oExpData` is a live operand
- `iExpResult`  in  RES_W  exp unit `oData`
- `oData`  out  RES_W  registered result
- `oDataValid`  out  1  registered one-cycle strobe
- `oDataId`  out  $clog2(N_REQ)  requester owning `oData`
- `oIdle`  out  1  state STOP and nothing in flight

## Operation
- FSM states: RUN, DRAIN, STOP. Reset state RUN.
- RUN: if any `iReq`, grant exactly one; iEn low -> DRAIN if in-flight count nonzero, else STOP.
- DRAIN: no grants; when in-flight count reaches 0 -> STOP. iEn high in DRAIN -> RUN next cycle.
- STOP: no grants; iEn high -> RUN.
- Arbitration: priority starts at (last granted + 1) mod N_REQ; pointer updates only on a grant. After reset requester 0 has highest priority.
- Grant handshake: requester i is served in the cycle `iReq[i] & oGnt[i]`; operand `iData[i]` is captured at that edge. Requester drops or replaces its request after the grant cycle; holding `iReq` high requests again and is served again only after the other active requesters.
- Tag pipe: LATENCY+1 stages of {valid, id}; stage 0 loads with the issue. In-flight counter (width $clog2(LATENCY+2)) increments on issue and decrements on result; simultaneous issue and retire leaves it unchanged.
- Result capture: when the tag exits, `oData <= iExpResult`, `oDataValid <= 1`, `oDataId <= id`; otherwise `oDataValid <= 0` and `oData`/`oDataId` hold.
- There is no output backpressure. Consumers must accept every strobe.

## Timing
- Reset values: `oExpData`=0, `oExpValid`=0, `oData`=0, `oDataValid`=0, `oDataId`=0, `oIdle`=0, RR pointer so that requester 0 wins first, tag pipe cleared, counter 0.
- Grant in cycle t -> `oExpValid`=1 in t+1 -> `oDataValid`=1 in t+LATENCY+2. Throughput is one result per cycle.
- `oGnt` depends only on the current `iReq`, state, and pointer. It has no path from `iData`.
- If reset is asserted mid-operation, all in-flight tags are discarded. Results emerging from the exp unit after reset are never flagged valid.
- iEn falling in the same cycle as a request: that cycle is still RUN and grants. Drain starts the next cycle.

## Configuration
- `EXP_SCHED_STATS_EN`: when defined, adds the output `oIssueCnt` (N_REQ*16) with per-requester saturating issue counters. The counters reset to 0, increment on a grant, and stick at 16'hFFFF. When undefined, neither the port nor the counters exist, and the behaviour is otherwise identical.

## Structure
- Shared package `exp_sched_pkg`: FSM state enum (`RUN`, `DRAIN`, `STOP`), the tag struct {valid, id}, and the default constants for LATENCY, DATA_W and RES_W.
- One sub-module, `rr_arbiter`: N-way round-robin, with inputs req and update-enable, and outputs a one-hot grant and a binary index.

## Test plan
- Single request: `iReq`=4'b0010, `iData[1]`=12'h0C0 (0.75) -> `oGnt`=4'b0010 in the same cycle; `oExpValid` with 12'h0C0 one cycle later; `oDataValid` with `oDataId`=1 after LATENCY+2 cycles, matching the exp model.
- All four requesting continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and 8 consecutive results with IDs in the same order.
- Requesters 0 and 2 only, after a grant to 3 -> order 0,2,0,2, with 1 and 3 never granted.
- iEn low with 3 in flight -> no grants, DRAIN for 3 result cycles, then STOP and `oIdle`=1; iEn high -> RUN and granting resumes the next cycle.
- rst_n pulsed while 4 results are in flight -> all outputs 0 immediately, and no `oDataValid` for the next LATENCY+2 cycles without new requests.
- With `EXP_SCHED_STATS_EN` defined, 70000 grants to requester 0 -> `oIssueCnt[0]`=16'hFFFF, other counters 0.

Source files
------------

// File: rtl/exp_sched_pkg.sv
// rtl/exp_sched_pkg.sv - shared types and default constants for the exp scheduler
package exp_sched_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    STOP  = 2'd2
  } state_t;

  // Default sizing of the shared exp unit and its operands
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_LATENCY = 6;
  localparam int DEF_DATA_W  = 12;
  localparam int DEF_RES_W   = 20;

  // Tag id field is sized for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;

  // One in-flight operand tracker: valid bit plus owning requester
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/exp_sched_rr_arbiter.sv
// rtl/exp_sched_rr_arbiter.sv - N-way round-robin arbiter with one-hot and binary grant
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          upd,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Index of the requester that currently holds highest priority
  logic [IW-1:0] ptr;
  logic          anyGnt;

  // Scan requesters starting at the pointer and pick the first active one
  always_comb begin
    gnt    = '0;
    idx    = '0;
    anyGnt = 1'b0;
    for (int i = 0; i < N; i++) begin
      int cand;
      cand = (int'(ptr) + i) % N;
      if (!anyGnt && req[cand]) begin
        anyGnt    = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

  // Advance priority to the requester after the winner, only when a grant is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (upd && anyGnt) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/exp_sched_rr.sv
// rtl/exp_sched_rr.sv - round-robin sharing of one pipelined exp unit; optional EXP_SCHED_STATS_EN issue counters
module exp_sched_rr
  import exp_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int LATENCY = DEF_LATENCY,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_W   = DEF_RES_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iEn,
  input  logic [N_REQ-1:0]          iReq,
  input  logic [N_REQ*DATA_W-1:0]   iData,
  output logic [N_REQ-1:0]          oGnt,
  output logic [DATA_W-1:0]         oExpData,
  output logic                      oExpValid,
  input  logic [RES_W-1:0]          iExpResult,
  output logic [RES_W-1:0]          oData,
  output logic                      oDataValid,
  output logic [$clog2(N_REQ)-1:0]  oDataId,
  output logic                      oIdle
`ifdef EXP_SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       oIssueCnt
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LATENCY + 2);

  state_t            state;
  logic              run;
  logic [N_REQ-1:0]  arbReq;
  logic [N_REQ-1:0]  arbGnt;
  logic [ID_W-1:0]   gntIdx;
  logic              issue;
  logic              retire;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  nextCnt;

  // Stage k holds the tag of the operand that entered the unit k cycles ago
  tag_t tagPipe [LATENCY+1];

  assign run    = (state == RUN);
  assign arbReq = iReq & {N_REQ{run}};
  assign oGnt   = arbGnt;
  assign issue  = |arbGnt;
  assign retire = tagPipe[LATENCY].valid;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arbReq),
    .upd   (run),
    .gnt   (arbGnt),
    .idx   (gntIdx)
  );

  // In-flight count after this cycle's issue and retire
  always_comb begin
    nextCnt = cnt;
    if (issue && !retire) begin
      nextCnt = cnt + 1'b1;
    end else if (!issue && retire) begin
      nextCnt = cnt - 1'b1;
    end
  end

  // Control FSM; idle flag is registered alongside the state it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      oIdle <= 1'b0;
    end else begin
      oIdle <= 1'b0;
      case (state)
        RUN: begin
          if (!iEn) begin
            if (nextCnt != '0) begin
              state <= DRAIN;
            end else begin
              state <= STOP;
              oIdle <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (iEn) begin
            state <= RUN;
          end else if (nextCnt == '0) begin
            state <= STOP;
            oIdle <= 1'b1;
          end
        end
        STOP: begin
          if (iEn) begin
            state <= RUN;
          end else begin
            oIdle <= (nextCnt == '0);
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Track the number of operands inside the exp unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= nextCnt;
    end
  end

  // Register the granted operand into the exp unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oExpData  <= '0;
      oExpValid <= 1'b0;
    end else begin
      oExpValid <= issue;
      if (issue) begin
        oExpData <= iData[int'(gntIdx)*DATA_W +: DATA_W];
      end
    end
  end

  // Tag shift register matched to the unit latency; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LATENCY; k++) begin
        tagPipe[k] <= '0;
      end
    end else begin
      tagPipe[0].valid <= issue;
      tagPipe[0].id    <= TAG_ID_W'(gntIdx);
      for (int k = 1; k <= LATENCY; k++) begin
        tagPipe[k] <= tagPipe[k-1];
      end
    end
  end

  // Capture the unit result when its tag exits and strobe it out with the owner id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oData      <= '0;
      oDataValid <= 1'b0;
      oDataId    <= '0;
    end else begin
      oDataValid <= retire;
      if (retire) begin
        oData   <= iExpResult;
        oDataId <= tagPipe[LATENCY].id[ID_W-1:0];
      end
    end
  end

`ifdef EXP_SCHED_STATS_EN
  logic [15:0] issueCnt [N_REQ];

  // Per-requester saturating grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        issueCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (arbGnt[i] && (issueCnt[i] != 16'hFFFF)) begin
          issueCnt[i] <= issueCnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten counters onto the stats port
  always_comb begin
    oIssueCnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      oIssueCnt[i*16 +: 16] = issueCnt[i];
    end
  end
`endif

endmodule
